lieat_idu_scbd: RTL and testbench
=================================

# lieat_idu_scbd

Parametrised long-instruction scoreboard for the decode/dispatch stage. It generalises the single outstanding-instruction tracker to DEPTH entries and 2^OPW long-op classes, and allows interleaved completion across classes. It records every dispatched long instruction (LSU load, mul/div, …) and reports RAW/WAW hazards to dispatch, JALR rs1 hazards to the IFU, and writeback-ordering hazards to the WBU. Within a class, entries retire in dispatch order.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- OPW, 2, width of the long-op class tag
- RGIDX, 5, register index width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  reset; asynchronous, active-low
- disp_ena  in  1  dispatch one long instruction this cycle; legal only when disp_ready=1
- disp_ready  out  1  ~full
- disp_op  in  OPW  class tag of the dispatched instruction
- disp_rs1en / disp_rs2en / disp_rdwen  in  1 each  operand-valid qualifiers
- disp_rs1 / disp_rs2 / disp_rd  in  RGIDX each  register indices
- remove_ena  in  1  one long instruction of class remove_op writes back this cycle
- remove_op  in  OPW  class tag being retired
- ifu_dep_rs1  in  RGIDX  JALR rs1 index from the IFU
- wbu_dep_rd  in  RGIDX  rd of the ordinary writeback
- raw_dep  out  1  dispatch rs1/rs2 hits an outstanding rd
- waw_dep  out  1  dispatch rd hits an outstanding rd
- ifu_dep  out  1  ifu_dep_rs1 hits an outstanding rd
- wbu_dep  out  1  wbu_dep_rd hits an outstanding rd
- empty  out  1  no valid entries
- count  out  clog2(DEPTH)+1  number of valid entries
- scbd_err  out  1  sticky; set when a remove has no match or a dispatch arrives while full

## Operation
- Entry state: valid, op[OPW], rdwen, rd[RGIDX], rank[clog2(DEPTH)].
- Rank is the number of older valid entries of the same class. The entry with rank 0 is the oldest of its class.
- Dispatch (disp_ena & disp_ready):
  - Allocates the lowest-index free entry.
  - rank = number of valid entries with op==disp_op, minus 1 if remove_ena & remove_op==disp_op and a matching entry exists this cycle.
- Remove (remove_ena):
  - Invalidates the valid entry with op==remove_op and rank==0.
  - Decrements rank of every other valid entry with op==remove_op.
  - With no matching entry: state unchanged, scbd_err set.
- Dispatch while full: ignored, scbd_err set.
- Simultaneous dispatch and remove are both applied in the same edge. A freed entry is not reusable in the same cycle; allocation uses pre-edge free slots.
- Hit definition: an entry hits index r when valid & rdwen & rd==r & r!=0. Register x0 never creates a dependency.
- raw_dep = (disp_rs1en & hit(disp_rs1)) | (disp_rs2en & hit(disp_rs2)).
- waw_dep = disp_rdwen & hit(disp_rd).
- ifu_dep = hit(ifu_dep_rs1).
- wbu_dep = hit(wbu_dep_rd).
- count = number of valid entries. empty = (count==0). full = (count==DEPTH).

## Timing
- Reset values: all entries invalid, rank 0; count=0, empty=1, disp_ready=1, scbd_err=0; all dep outputs 0.
- Dependency outputs are combinational from entry state and the current index inputs. They carry no path from disp_ena.
- A dispatched entry becomes visible to the dep outputs and count the cycle after disp_ena.
- The removal visibility is set by the configuration below.
- Reset asserted mid-operation clears all entries immediately. scbd_err clears only on reset.

## Configuration
- LIEAT_SCBD_BYPASS_EN:
  - Defined: the entry being removed this cycle (selected by remove_ena/remove_op) is masked out of all four hit comparisons in the same cycle. Dependent instructions may dispatch in the writeback cycle.
  - Undefined: hit comparisons use registered state only. A dependency clears the cycle after remove_ena.
  - Entry state updates are identical in both builds.

## Test plan
- Reset, then dispatch op=1, rd=5. Next cycle: count=1, empty=0; raw_dep=1 for disp_rs1en=1, rs1=5; raw_dep=0 for rs1=0.
- Fill DEPTH=4 entries (rd=1..4, all op=0) → disp_ready=0. Assert disp_ena anyway → state unchanged, scbd_err=1.
- Dispatch op0 rd=3, then op1 rd=7, then op0 rd=9. Remove op=0 → rd=3 entry is cleared; rd=7 and rd=9 remain; the rd=9 entry's rank becomes 0.
- Same-cycle dispatch op0 rd=6 and remove op0 with one op0 entry present → next cycle count unchanged and the new entry has rank 0. A following remove op0 clears rd=6.
- Remove op=2 with no op2 entry → no state change, scbd_err=1.
- Outstanding rd=8; in the remove cycle drive ifu_dep_rs1=8 → ifu_dep=0 with LIEAT_SCBD_BYPASS_EN defined, ifu_dep=1 without it (0 one cycle later).

Source files
------------

// File: rtl/lieat_idu_scbd.sv
// rtl/lieat_idu_scbd.sv - long-instruction scoreboard for decode/dispatch
//
// Tracks up to DEPTH outstanding long instructions across 2^OPW classes.
// Entries of one class retire in dispatch order: each entry carries a rank
// equal to the number of older valid entries of its class.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   disp_*                    dispatch request, operand qualifiers and indices
//   disp_ready                scoreboard not full
//   remove_ena, remove_op     retire the oldest entry of class remove_op
//   ifu_dep_rs1, wbu_dep_rd   extra lookup indices for IFU (JALR) and WBU
//   raw_dep, waw_dep          dispatch hazards
//   ifu_dep, wbu_dep          lookup hazards
//   empty, count              occupancy
//   scbd_err                  sticky protocol error
//
// Build option: LIEAT_SCBD_BYPASS_EN masks the entry retiring this cycle out
// of all hazard comparisons.

module lieat_idu_scbd #(
    parameter int DEPTH = 4,
    parameter int OPW   = 2,
    parameter int RGIDX = 5
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      disp_ena,
    output logic                      disp_ready,
    input  logic [OPW-1:0]            disp_op,
    input  logic                      disp_rs1en,
    input  logic                      disp_rs2en,
    input  logic                      disp_rdwen,
    input  logic [RGIDX-1:0]          disp_rs1,
    input  logic [RGIDX-1:0]          disp_rs2,
    input  logic [RGIDX-1:0]          disp_rd,
    input  logic                      remove_ena,
    input  logic [OPW-1:0]            remove_op,
    input  logic [RGIDX-1:0]          ifu_dep_rs1,
    input  logic [RGIDX-1:0]          wbu_dep_rd,
    output logic                      raw_dep,
    output logic                      waw_dep,
    output logic                      ifu_dep,
    output logic                      wbu_dep,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      scbd_err
);

    localparam int RW = $clog2(DEPTH);
    localparam int CW = RW + 1;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] rdwen_q;
    logic [OPW-1:0]   op_q   [DEPTH];
    logic [RGIDX-1:0] rd_q   [DEPTH];
    logic [RW-1:0]    rank_q [DEPTH];

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    same_cnt;
    logic [DEPTH-1:0] cls_rm;
    logic [DEPTH-1:0] rm_sel;
    logic [DEPTH-1:0] live;
    logic             rm_hit;
    logic             full;
    logic             do_disp;
    logic             found;
    logic [RW-1:0]    alloc_idx;
    logic [RW-1:0]    disp_rank;
    logic             h_rs1, h_rs2, h_rd, h_ifu, h_wbu;

    always_comb begin
        cnt       = '0;
        same_cnt  = '0;
        cls_rm    = '0;
        rm_sel    = '0;
        alloc_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                cnt = cnt + CW'(1);
                if (op_q[i] == disp_op) same_cnt = same_cnt + CW'(1);
            end
            cls_rm[i] = valid_q[i] && remove_ena && (op_q[i] == remove_op);
            rm_sel[i] = cls_rm[i] && (rank_q[i] == '0);
            // allocation only ever looks at slots free before this edge
            if (!found && !valid_q[i]) begin
                alloc_idx = RW'(i);
                found     = 1'b1;
            end
        end
        rm_hit  = |rm_sel;
        full    = (cnt == CW'(DEPTH));
        do_disp = disp_ena && !full;
        // a same-class retirement in this cycle makes the new entry one rank younger-free
        disp_rank = RW'(same_cnt - CW'(remove_ena && (remove_op == disp_op) && rm_hit));
    end

`ifdef LIEAT_SCBD_BYPASS_EN
    assign live = valid_q & rdwen_q & ~rm_sel;
`else
    assign live = valid_q & rdwen_q;
`endif

    always_comb begin
        h_rs1 = 1'b0;
        h_rs2 = 1'b0;
        h_rd  = 1'b0;
        h_ifu = 1'b0;
        h_wbu = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) begin
                if (rd_q[i] == disp_rs1)    h_rs1 = 1'b1;
                if (rd_q[i] == disp_rs2)    h_rs2 = 1'b1;
                if (rd_q[i] == disp_rd)     h_rd  = 1'b1;
                if (rd_q[i] == ifu_dep_rs1) h_ifu = 1'b1;
                if (rd_q[i] == wbu_dep_rd)  h_wbu = 1'b1;
            end
        end
    end

    // x0 never creates a dependency
    assign raw_dep    = (disp_rs1en && h_rs1 && (|disp_rs1)) ||
                        (disp_rs2en && h_rs2 && (|disp_rs2));
    assign waw_dep    = disp_rdwen && h_rd && (|disp_rd);
    assign ifu_dep    = h_ifu && (|ifu_dep_rs1);
    assign wbu_dep    = h_wbu && (|wbu_dep_rd);
    assign count      = cnt;
    assign empty      = (cnt == '0);
    assign disp_ready = !full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q  <= '0;
            rdwen_q  <= '0;
            scbd_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                rd_q[i]   <= '0;
                rank_q[i] <= '0;
            end
        end else begin
            if ((disp_ena && full) || (remove_ena && !rm_hit)) scbd_err <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (rm_sel[i]) begin
                    valid_q[i] <= 1'b0;
                    rank_q[i]  <= '0;
                end else if (cls_rm[i] && rm_hit) begin
                    rank_q[i] <= rank_q[i] - RW'(1);
                end
                if (do_disp && (alloc_idx == RW'(i))) begin
                    valid_q[i] <= 1'b1;
                    rdwen_q[i] <= disp_rdwen;
                    op_q[i]    <= disp_op;
                    rd_q[i]    <= disp_rd;
                    rank_q[i]  <= disp_rank;
                end
            end
        end
    end

endmodule

// File: tb/tb_lieat_idu_scbd.sv
// tb/tb_lieat_idu_scbd.sv - scoreboard-checked directed bench for lieat_idu_scbd

module tb_lieat_idu_scbd;

    localparam int DEPTH = 4;
    localparam int OPW   = 2;
    localparam int RGIDX = 5;

    logic             clk;
    logic             rstn;
    logic             disp_ena;
    logic             disp_ready;
    logic [OPW-1:0]   disp_op;
    logic             disp_rs1en, disp_rs2en, disp_rdwen;
    logic [RGIDX-1:0] disp_rs1, disp_rs2, disp_rd;
    logic             remove_ena;
    logic [OPW-1:0]   remove_op;
    logic [RGIDX-1:0] ifu_dep_rs1, wbu_dep_rd;
    logic             raw_dep, waw_dep, ifu_dep, wbu_dep, empty, scbd_err;
    logic [$clog2(DEPTH):0] count;

    lieat_idu_scbd #(.DEPTH(DEPTH), .OPW(OPW), .RGIDX(RGIDX)) dut (
        .clk(clk), .rstn(rstn),
        .disp_ena(disp_ena), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en), .disp_rdwen(disp_rdwen),
        .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rd(disp_rd),
        .remove_ena(remove_ena), .remove_op(remove_op),
        .ifu_dep_rs1(ifu_dep_rs1), .wbu_dep_rd(wbu_dep_rd),
        .raw_dep(raw_dep), .waw_dep(waw_dep), .ifu_dep(ifu_dep), .wbu_dep(wbu_dep),
        .empty(empty), .count(count), .scbd_err(scbd_err)
    );

    localparam int F_CNT = 0, F_EMPTY = 1, F_READY = 2, F_ERR = 3;
    localparam int F_RAW = 4, F_WAW = 5, F_IFU = 6, F_WBU = 7;

    typedef struct {
        int    cyc;
        string name;
        int    fid;
        int    val;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;
    bit   done   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int field(int f);
        case (f)
            F_CNT:   return int'(count);
            F_EMPTY: return int'(empty);
            F_READY: return int'(disp_ready);
            F_ERR:   return int'(scbd_err);
            F_RAW:   return int'(raw_dep);
            F_WAW:   return int'(waw_dep);
            F_IFU:   return int'(ifu_dep);
            default: return int'(wbu_dep);
        endcase
    endfunction

    // monitor: pops every expectation queued for this cycle, compares off-edge
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            int   act;
            e   = q.pop_front();
            act = field(e.fid);
            total++;
            if (act == e.val) passed++;
            else $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
        end
    end

    task automatic expect_v(string n, int f, int v);
        exp_t e;
        e.cyc = cyc; e.name = n; e.fid = f; e.val = v;
        q.push_back(e);
    endtask

    task automatic idle();
        disp_ena = 0; disp_op = '0; disp_rs1en = 0; disp_rs2en = 0; disp_rdwen = 0;
        disp_rs1 = '0; disp_rs2 = '0; disp_rd = '0;
        remove_ena = 0; remove_op = '0; ifu_dep_rs1 = '0; wbu_dep_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic disp(int op, int rd);
        disp_ena = 1; disp_op = OPW'(op); disp_rdwen = 1; disp_rd = RGIDX'(rd);
    endtask

    task automatic rem(int op);
        remove_ena = 1; remove_op = OPW'(op);
    endtask

    initial begin
        rstn = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1;

        // reset state
        disp_rs1en = 1; disp_rs1 = 5; ifu_dep_rs1 = 5; wbu_dep_rd = 5;
        expect_v("rst_count", F_CNT, 0);
        expect_v("rst_empty", F_EMPTY, 1);
        expect_v("rst_ready", F_READY, 1);
        expect_v("rst_err", F_ERR, 0);
        expect_v("rst_raw", F_RAW, 0);
        expect_v("rst_ifu", F_IFU, 0);
        expect_v("rst_wbu", F_WBU, 0);
        tick();

        // dispatch op1 rd5; not visible in the dispatch cycle
        disp(1, 5);
        expect_v("disp_same_cycle_count", F_CNT, 0);
        tick();
        disp_rs1en = 1; disp_rs1 = 5; wbu_dep_rd = 5;
        expect_v("after_disp_count", F_CNT, 1);
        expect_v("after_disp_empty", F_EMPTY, 0);
        expect_v("raw_rs1_5", F_RAW, 1);
        expect_v("wbu_5", F_WBU, 1);
        tick();
        disp_rs1en = 1; disp_rs1 = 0; disp_rdwen = 1; disp_rd = 5;
        expect_v("raw_rs1_0", F_RAW, 0);
        expect_v("waw_rd5_no_ena", F_WAW, 1);
        tick();
        disp_rs2en = 1; disp_rs2 = 5;
        expect_v("raw_rs2_5", F_RAW, 1);
        tick();

        // retire it; visibility depends on the bypass build
        rem(1); wbu_dep_rd = 5;
`ifdef LIEAT_SCBD_BYPASS_EN
        expect_v("wbu_rm_cycle", F_WBU, 0);
`else
        expect_v("wbu_rm_cycle", F_WBU, 1);
`endif
        tick();
        wbu_dep_rd = 5;
        expect_v("wbu_after_rm", F_WBU, 0);
        expect_v("count_after_rm", F_CNT, 0);
        expect_v("err_after_rm", F_ERR, 0);
        tick();

        // fill to DEPTH
        for (int r = 1; r <= DEPTH; r++) begin
            disp(0, r);
            tick();
        end
        disp(0, 10); ifu_dep_rs1 = 4;
        expect_v("full_ready", F_READY, 0);
        expect_v("full_count", F_CNT, 4);
        expect_v("full_ifu_4", F_IFU, 1);
        expect_v("full_err_pre", F_ERR, 0);
        tick();
        disp_rdwen = 1; disp_rd = 10;
        expect_v("full_drop_count", F_CNT, 4);
        expect_v("full_drop_err", F_ERR, 1);
        expect_v("full_drop_waw10", F_WAW, 0);
        tick();

        // asynchronous reset mid-operation
        rstn = 0;
        expect_v("midrst_count", F_CNT, 0);
        expect_v("midrst_err", F_ERR, 0);
        expect_v("midrst_ready", F_READY, 1);
        tick();
        rstn = 1;
        tick();

        // in-class ordering across interleaved classes
        disp(0, 3); tick();
        disp(1, 7); tick();
        disp(0, 9); tick();
        expect_v("three_count", F_CNT, 3);
        rem(0);
        tick();
        wbu_dep_rd = 3; ifu_dep_rs1 = 7; disp_rs1en = 1; disp_rs1 = 9;
        expect_v("ord_rd3_gone", F_WBU, 0);
        expect_v("ord_rd7_left", F_IFU, 1);
        expect_v("ord_rd9_left", F_RAW, 1);
        expect_v("ord_count2", F_CNT, 2);
        tick();
        rem(0);
        tick();
        wbu_dep_rd = 9; ifu_dep_rs1 = 7;
        expect_v("ord_rd9_gone", F_WBU, 0);
        expect_v("ord_rd7_still", F_IFU, 1);
        expect_v("ord_err", F_ERR, 0);
        tick();
        rem(1);
        tick();

        // same-cycle dispatch and remove of the same class
        disp(0, 2); tick();
        disp(0, 6); rem(0);
        tick();
        wbu_dep_rd = 2; ifu_dep_rs1 = 6;
        expect_v("sc_count", F_CNT, 1);
        expect_v("sc_rd2_gone", F_WBU, 0);
        expect_v("sc_rd6_present", F_IFU, 1);
        tick();
        rem(0);
        tick();
        ifu_dep_rs1 = 6;
        expect_v("sc_rd6_gone", F_IFU, 0);
        expect_v("sc_count0", F_CNT, 0);
        expect_v("sc_err", F_ERR, 0);
        tick();

        // x0 never hits
        disp(2, 0); tick();
        ifu_dep_rs1 = 0; disp_rdwen = 1; disp_rd = 0;
        expect_v("x0_count", F_CNT, 1);
        expect_v("x0_ifu", F_IFU, 0);
        expect_v("x0_waw", F_WAW, 0);
        tick();
        rem(2); tick();

        // remove with no matching class
        rem(2);
        tick();
        expect_v("nomatch_err", F_ERR, 1);
        expect_v("nomatch_count", F_CNT, 0);
        tick();

        // JALR bypass window
        disp(3, 8); tick();
        tick();
        rem(3); ifu_dep_rs1 = 8;
`ifdef LIEAT_SCBD_BYPASS_EN
        expect_v("ifu_rm_cycle", F_IFU, 0);
`else
        expect_v("ifu_rm_cycle", F_IFU, 1);
`endif
        tick();
        ifu_dep_rs1 = 8;
        expect_v("ifu_after_rm", F_IFU, 0);
        expect_v("ifu_after_empty", F_EMPTY, 1);
        tick();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL leftover_expectations: got %0d expected 0", q.size());
        end
        done = 1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected finish");
            $fatal(1, "watchdog");
        end
    end

endmodule
